// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the execute stage (aluop classes, funct codes, ALU ops, FSM states); ST_MUL exists only with EX_MULT_EN
package pipeline_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MULT = 6'b011000;

    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_NOP} alu_op_e;

`ifdef EX_MULT_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_MUL} state_e;
`else
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL} state_e;
`endif

    // aluop 11 is treated like a plain add; unknown R-type functs map to OP_NOP (result 0)
    function automatic alu_op_e alu_ctl(input logic [1:0] aluop, input logic [5:0] funct);
        return aluop == ALUOP_SUB   ? OP_SUB :
               aluop != ALUOP_RTYPE ? OP_ADD :
               funct == F_ADD       ? OP_ADD :
               funct == F_SUB       ? OP_SUB :
               funct == F_AND       ? OP_AND :
               funct == F_OR        ? OP_OR  :
               funct == F_SLT       ? OP_SLT :
               funct == F_MULT      ? OP_MUL : OP_NOP;
    endfunction

endpackage

// File: rtl/ex_multiplier.sv
// ex_multiplier: iterative unsigned shift-add multiplier returning the low word; done and product are valid during the final iteration
module ex_multiplier #(
    parameter int W      = 32,
    parameter int CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [W-1:0]  acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, step_acc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy     = busy_q;
    assign done     = busy_q && cnt_q == CW'(1);
    assign product  = step_acc;

    // one partial product per cycle; the final step is exposed combinationally so the caller can register it on the same edge
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CW'(CYCLES);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            busy_d   = cnt_q != CW'(1);
        end
    end

    // iteration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage (ALU, branch target, destination select) with a registered valid/ready EX/MEM bundle; EX_MULT_EN adds an iterative MULT
module ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        wb_ctl,
    input  logic [2:0]        m_ctl,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extend,
    input  logic [4:0]        instr_2016,
    input  logic [4:0]        instr_1511,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        wb_ctl_out,
    output logic [2:0]        m_ctl_out,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] store_data,
    output logic [4:0]        write_reg
);

    if (MUL_CYCLES != DATA_W) begin : g_cfg_check
        $error("ex_stage: MUL_CYCLES must equal DATA_W");
    end

    state_e             state_q, state_d;
    logic [1:0]         wb_ctl_q, wb_ctl_d;
    logic [2:0]         m_ctl_q, m_ctl_d;
    logic [DATA_W-1:0]  alu_result_q, alu_result_d, branch_target_q, branch_target_d, store_data_q, store_data_d;
    logic               zero_q, zero_d;
    logic [4:0]         write_reg_q, write_reg_d;
    alu_op_e            op;
    logic [DATA_W-1:0]  op_b, alu_y;
    logic               accept;

    assign op        = alu_ctl(aluop, s_extend[5:0]);
    assign op_b      = alusrc ? s_extend : rdata2;
    assign in_ready  = state_q == ST_EMPTY || (state_q == ST_FULL && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = state_q == ST_FULL;

    assign alu_y = op == OP_ADD ? rdata1 + op_b :
                   op == OP_SUB ? rdata1 - op_b :
                   op == OP_AND ? rdata1 & op_b :
                   op == OP_OR  ? rdata1 | op_b :
                   op == OP_SLT ? DATA_W'($signed(rdata1) < $signed(op_b)) : '0;

    assign wb_ctl_out    = wb_ctl_q;
    assign m_ctl_out     = m_ctl_q;
    assign alu_result    = alu_result_q;
    assign zero          = zero_q;
    assign branch_target = branch_target_q;
    assign store_data    = store_data_q;
    assign write_reg     = write_reg_q;

`ifdef EX_MULT_EN
    logic              mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    ex_multiplier #(.W(DATA_W), .CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && op == OP_MUL),
        .abort   (flush),
        .a       (rdata1),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // next state and output bundle: load on accept, drain on out_ready, flush always empties the stage
    always_comb begin
        state_d         = state_q;
        wb_ctl_d        = wb_ctl_q;
        m_ctl_d         = m_ctl_q;
        alu_result_d    = alu_result_q;
        zero_d          = zero_q;
        branch_target_d = branch_target_q;
        store_data_d    = store_data_q;
        write_reg_d     = write_reg_q;
        if (accept) begin
            wb_ctl_d        = wb_ctl;
            m_ctl_d         = m_ctl;
            alu_result_d    = alu_y;
            zero_d          = alu_y == '0;
            branch_target_d = npc + (s_extend << 2);
            store_data_d    = rdata2;
            write_reg_d     = regdst ? instr_1511 : instr_2016;
            state_d         = ST_FULL;
`ifdef EX_MULT_EN
            if (op == OP_MUL) state_d = ST_MUL;
`endif
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
`ifdef EX_MULT_EN
        else if (state_q == ST_MUL) begin
            if (mul_done) begin
                state_d      = ST_FULL;
                alu_result_d = mul_product;
                zero_d       = mul_product == '0;
            end else if (!mul_busy) begin
                state_d = ST_EMPTY;
            end
        end
`endif
        if (flush) state_d = ST_EMPTY;
    end

    // state and EX/MEM bundle registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_EMPTY;
            wb_ctl_q        <= '0;
            m_ctl_q         <= '0;
            alu_result_q    <= '0;
            zero_q          <= 1'b0;
            branch_target_q <= '0;
            store_data_q    <= '0;
            write_reg_q     <= '0;
        end else begin
            state_q         <= state_d;
            wb_ctl_q        <= wb_ctl_d;
            m_ctl_q         <= m_ctl_d;
            alu_result_q    <= alu_result_d;
            zero_q          <= zero_d;
            branch_target_q <= branch_target_d;
            store_data_q    <= store_data_d;
            write_reg_q     <= write_reg_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and burst checks of ex_stage with a scoreboard of expected EX/MEM bundles
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, regdst, alusrc, flush, out_valid, zero;
    logic        ready_drv, rnd_ready, bp_rand, out_ready;
    logic [1:0]  wb_ctl, aluop, wb_ctl_out;
    logic [2:0]  m_ctl, m_ctl_out;
    logic [31:0] npc, rdata1, rdata2, s_extend, alu_result, branch_target, store_data;
    logic [4:0]  instr_2016, instr_1511, write_reg;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wreg;
        logic [31:0] bt;
        logic [31:0] sd;
        logic [1:0]  wb;
        logic [2:0]  m;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int outs   = 0;
    int pushed = 0;
    int busy;

    assign out_ready = bp_rand ? rnd_ready : ready_drv;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc), .aluop(aluop),
        .npc(npc), .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
        .instr_2016(instr_2016), .instr_1511(instr_1511), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .wb_ctl_out(wb_ctl_out),
        .m_ctl_out(m_ctl_out), .alu_result(alu_result), .zero(zero),
        .branch_target(branch_target), .store_data(store_data), .write_reg(write_reg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zeroed(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_res"}, alu_result, 0);
        chk({tag, "_zero"}, zero, 0);
        chk({tag, "_bt"}, branch_target, 0);
        chk({tag, "_sd"}, store_data, 0);
        chk({tag, "_wreg"}, write_reg, 0);
        chk({tag, "_ctl"}, {wb_ctl_out, m_ctl_out}, 0);
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] aop, input logic src,
                                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        logic [31:0] y;
        y = src ? imm : b;
        if (aop == 2'b01) return a - y;
        if (aop != 2'b10) return a + y;
        case (imm[5:0])
            6'h20:   return a + y;
            6'h22:   return a - y;
            6'h24:   return a & y;
            6'h25:   return a | y;
            6'h2A:   return {31'b0, $signed(a) < $signed(y)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] aop, input logic src, input logic rdst,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] res, input bit push);
        exp_t e;
        bit   ok;
        aluop = aop; alusrc = src; regdst = rdst; rdata1 = a; rdata2 = b;
        s_extend = imm; npc = pc; instr_2016 = rt; instr_1511 = rd;
        wb_ctl = 2'($urandom); m_ctl = 3'($urandom); in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", in_ready, 1);
        else if (push) begin
            e.res = res; e.wreg = rdst ? rd : rt; e.bt = pc + (imm << 2);
            e.sd = b; e.wb = wb_ctl; e.m = m_ctl;
            q.push_back(e);
            pushed++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // scoreboard: every transfer (out_valid & out_ready) must match the oldest expected bundle
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                outs++;
                chk("res", alu_result, e.res);
                chk("zero", zero, e.res == 0);
                chk("wreg", write_reg, e.wreg);
                chk("bt", branch_target, e.bt);
                chk("sd", store_data, e.sd);
                chk("wb", wb_ctl_out, e.wb);
                chk("m", m_ctl_out, e.m);
            end
        end
    end

    initial begin
        logic [1:0]  aop;
        logic        src;
        logic [31:0] a, b, imm;
        logic [5:0]  functs [6];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
        rst = 1'b1; in_valid = 0; flush = 0; regdst = 0; alusrc = 0; aluop = 0;
        wb_ctl = 0; m_ctl = 0; npc = 0; rdata1 = 0; rdata2 = 0; s_extend = 0;
        instr_2016 = 0; instr_1511 = 0; ready_drv = 1; rnd_ready = 1; bp_rand = 0;
        #2;
        chk_zeroed("reset");
        idle(2);
        rst = 1'b0;

        // R-type ops on 7 and 5, rd = 9
        issue(2'b10, 0, 1, 7, 5, 32'h20, 32'h100, 5'd3, 5'd9, 12, 1);
        chk("lat_valid", out_valid, 1);
        chk("lat_wreg", write_reg, 9);
        issue(2'b10, 0, 1, 7, 5, 32'h22, 32'h104, 5'd3, 5'd9, 2, 1);
        issue(2'b10, 0, 1, 7, 5, 32'h24, 32'h108, 5'd3, 5'd9, 5, 1);
        issue(2'b10, 0, 1, 7, 5, 32'h25, 32'h10C, 5'd3, 5'd9, 7, 1);
        issue(2'b10, 0, 1, 7, 5, 32'h2A, 32'h110, 5'd3, 5'd9, 0, 1);
        issue(2'b10, 0, 1, 32'hFFFFFFFF, 1, 32'h2A, 32'h114, 5'd3, 5'd9, 1, 1);
        issue(2'b10, 0, 1, 33, 33, 32'h22, 32'h118, 5'd3, 5'd9, 0, 1);
        chk("sub_eq_zero", zero, 1);
        issue(2'b10, 0, 1, 7, 5, 32'h3F, 32'h11C, 5'd3, 5'd9, 0, 1);
        issue(2'b11, 0, 0, 32'hFFFFFFFF, 2, 32'h0, 32'h120, 5'd4, 5'd9, 1, 1);
        issue(2'b01, 0, 0, 0, 1, 32'h0, 32'h124, 5'd4, 5'd9, 32'hFFFFFFFF, 1);

        // lw-style address with negative immediate
        issue(2'b00, 1, 0, 32'h100, 32'hDEAD, 32'hFFFFFFFC, 32'h40, 5'd4, 5'd9, 32'hFC, 1);
        chk("lw_res", alu_result, 32'hFC);
        chk("lw_bt", branch_target, 32'h30);
        chk("lw_wreg", write_reg, 4);
        idle(2);
        chk("drained_valid", out_valid, 0);
        chk("drained_in_ready", in_ready, 1);

        // back-pressure: A is held while B waits
        ready_drv = 0;
        issue(2'b00, 0, 1, 100, 23, 32'h0, 32'h200, 5'd1, 5'd2, 123, 1);
        in_valid = 1;
        rdata1 = 1; rdata2 = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold", alu_result, 123);
            chk("bp_hold_wreg", write_reg, 2);
        end
        @(posedge clk);
        #1;
        ready_drv = 1;
        issue(2'b00, 0, 1, 1, 2, 32'h0, 32'h204, 5'd1, 5'd2, 3, 1);
        issue(2'b01, 0, 1, 9, 4, 32'h0, 32'h208, 5'd1, 5'd6, 5, 1);

        // random burst with random downstream readiness
        bp_rand = 1;
        for (int n = 0; n < 24; n++) begin
            aop = 2'($urandom);
            src = aop == 2'b10 ? 1'b0 : 1'($urandom);
            a = $urandom; b = $urandom;
            imm = {$urandom} & 32'hFFFFFFC0 | {26'b0, functs[$urandom_range(0, 5)]};
            issue(aop, src, 1'($urandom), a, b, imm, $urandom, 5'($urandom), 5'($urandom),
                  ref_res(aop, src, a, b, imm), 1);
        end
        bp_rand = 0;
        idle(4);
        chk("burst_drained", q.size(), 0);

        // MULT 6 x 7
`ifdef EX_MULT_EN
        issue(2'b10, 0, 1, 6, 7, 32'h18, 32'h300, 5'd1, 5'd2, 42, 1);
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
            busy++;
        end
        chk("mul_busy_cycles", busy, 32);
        chk("mul_valid", out_valid, 1);
        chk("mul_res", alu_result, 42);
        idle(2);
        issue(2'b10, 0, 1, 6, 7, 32'h18, 32'h300, 5'd1, 5'd2, 0, 0);
        idle(5);
        flush = 1;
        idle(1);
        flush = 0;
        chk("mul_flush_in_ready", in_ready, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("mul_flush_valid", out_valid, 0);
        idle(1);
        issue(2'b10, 0, 1, 6, 7, 32'h18, 32'h300, 5'd1, 5'd2, 0, 0);
        idle(5);
        rst = 1;
        #1;
        chk_zeroed("rst_mul");
        idle(1);
        rst = 0;
`else
        issue(2'b10, 0, 1, 6, 7, 32'h18, 32'h300, 5'd1, 5'd2, 0, 1);
        chk("mul_off_valid", out_valid, 1);
        chk("mul_off_res", alu_result, 0);
        idle(2);
`endif

        // flush together with in_valid drops the bundle
        in_valid = 1; flush = 1; aluop = 0; rdata1 = 55; rdata2 = 1;
        idle(1);
        in_valid = 0; flush = 0;
        @(negedge clk);
        chk("flush_drop_valid", out_valid, 0);
        chk("flush_drop_in_ready", in_ready, 1);
        idle(1);

        // async reset while a held result sits in the stage
        ready_drv = 0;
        issue(2'b00, 0, 1, 3, 4, 32'h1, 32'h400, 5'd7, 5'd8, 0, 0);
        chk("pre_rst_valid", out_valid, 1);
        rst = 1;
        #1;
        chk_zeroed("rst_full");
        idle(1);
        rst = 0;
        ready_drv = 1;
        idle(3);

        chk("queue_empty", q.size(), 0);
        chk("out_count", outs, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage that consumes the ID/EX register bundle (control, npc, operands, sign-extended immediate, rt/rd fields).
- Performs ALU-control decode, the ALU operation, branch-target computation and destination-register select.
- Presents the results as a registered EX/MEM bundle with valid/ready flow control.
- Most operations take one cycle. An optional iterative multiplier makes MULT a multi-cycle operation, so the block carries an FSM and back-pressure.

Parameters:
DATA_W, 32, datapath width (operands, npc, results)
MUL_CYCLES, 32, iterations of the shift-add multiplier (must equal DATA_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  ID/EX bundle valid
in_ready  output  1  stage can accept bundle this cycle
wb_ctl  input  2  WB control, passed through
m_ctl  input  3  MEM control, passed through
regdst  input  1  1: write reg = rd, 0: rt
alusrc  input  1  1: operand B = s_extend, 0: rdata2
aluop  input  2  ALU op class
npc  input  DATA_W  next PC
rdata1  input  DATA_W  operand A
rdata2  input  DATA_W  register operand B / store data
s_extend  input  DATA_W  sign-extended immediate; [5:0] = funct
instr_2016  input  5  rt field
instr_1511  input  5  rd field
flush  input  1  squash held/in-flight result
out_valid  output  1  EX/MEM bundle valid
out_ready  input  1  downstream accepts bundle
wb_ctl_out  output  2  registered wb_ctl
m_ctl_out  output  3  registered m_ctl
alu_result  output  DATA_W  ALU result
zero  output  1  alu_result == 0
branch_target  output  DATA_W  npc + (s_extend << 2), modulo 2^DATA_W
store_data  output  DATA_W  registered rdata2
write_reg  output  5  selected destination register

Behaviour:
- Reset, asynchronous: state = EMPTY; every output register = 0; out_valid = 0; in_ready = 1.
- FSM states: EMPTY, FULL, MUL.
- in_ready = (state == EMPTY) or (state == FULL and out_ready). in_ready is always 0 in MUL.
- Accept = in_valid & in_ready & ~flush.
- On accept of a non-MULT op:
  - All outputs register in the same edge.
  - Next state = FULL; out_valid = 1 the following cycle (1-cycle latency).
- Back-to-back: in FULL with out_ready = 1 and a new accept, the output is replaced in the same edge; throughput is 1 per cycle.
- FULL with out_ready = 1 and no accept -> EMPTY; out_valid = 0.
- FULL with out_ready = 0 -> hold all outputs stable.
- ALU control:
  - aluop 00 -> ADD.
  - aluop 01 -> SUB.
  - aluop 10 -> decode funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed, result 1 or 0), 011000 MULT.
  - aluop 10 with any other funct -> result 0.
  - aluop 11 -> ADD.
- Arithmetic: ADD and SUB wrap modulo 2^DATA_W; no overflow flag.
- MULT (only when EX_MULT_EN is defined):
  - Accept latches operands and control; state -> MUL.
  - Shift-add runs for MUL_CYCLES cycles, unsigned, keeping the low DATA_W bits of the product.
  - Then state -> FULL with out_valid = 1; latency is MUL_CYCLES + 1 edges.
- flush:
  - Clears out_valid and aborts MUL; state -> EMPTY next edge.
  - flush wins over a simultaneous accept; that bundle is dropped.
- Reset asserted mid-MUL returns immediately to EMPTY with all outputs 0.

Optional Feature:
- EX_MULT_EN defined: MULT funct 011000 is executed by the iterative multiplier; the MUL state exists.
- EX_MULT_EN undefined: no multiplier and no MUL state. Funct 011000 falls into the default case (result 0, 1 cycle).

Decomposition:
- Shared package (pipeline_pkg) holds:
  - aluop encodings
  - funct constants
  - internal ALU op enum: ADD, SUB, AND, OR, SLT, MUL, NOP
  - FSM state enum
- One sub-module, ex_multiplier: start/busy/done handshake, operands in, low-word product out. Instantiated only under EX_MULT_EN.

Test Plan:
- Reset: rst pulse -> all outputs 0, out_valid = 0, in_ready = 1; rst during MUL -> EMPTY and outputs 0 at once.
- R-type ADD/SUB/AND/OR/SLT, aluop = 10, regdst = 1, rdata1 = 7, rdata2 = 5, rd = 9:
  - results 12, 2, 5, 7, 0 one cycle after accept; write_reg = 9.
  - SLT with A = -1, B = 1 -> 1.
  - SUB with equal operands -> zero = 1.
- lw-style op (aluop = 00, alusrc = 1, rdata1 = 0x100, s_extend = 0xFFFFFFFC, npc = 0x40):
  - alu_result = 0xFC, write_reg = rt.
  - branch_target = 0x40 + 0xFFFFFFF0 = 0x30.
- Back-pressure: hold out_ready = 0 while in_valid = 1 -> outputs stable, in_ready = 0. Raise out_ready -> one bundle per cycle, none lost or duplicated.
- MULT (EX_MULT_EN) 6 × 7 -> in_ready = 0 for 32 cycles, then alu_result = 42, out_valid = 1. Same stimulus without the macro -> 0 after 1 cycle.
- flush during MUL, and flush coinciding with in_valid -> out_valid never asserts for the squashed ops; state returns to EMPTY.
